vadc_capture: RTL and testbench

- Capture-side counterpart of the video DAC path: accepts 8-bit RGB with hsync/vsync from an external digitizer or loopback source.
- Quantizes each component to the 5-bit TS-Conf colour code, with a linear-LUT inverse mode and a truncation mode.
- Tracks the beam position from the sync edges and windows the active area.
- Delivers pixels through a 4-entry FIFO with a valid/ready stream to a frame-grabber/DMA consumer.

---
 rtl/vadc_pkg.sv | 32 +++
 rtl/vadc_fifo.sv | 64 ++++++
 rtl/vadc_capture.sv | 153 +++++++++++++++
 tb/tb_vadc_capture.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vadc_pkg.sv
// Shared types and helpers for the video capture path: pixel/entry layouts,
// colour quantizer and sync edge detection.
package vadc_pkg;

  localparam int PIX_W   = 15;
  localparam int COORD_W = 10;
  localparam int ENTRY_W = PIX_W + 2 * COORD_W;

  typedef struct packed {
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
  } pix_t;

  typedef struct packed {
    pix_t               pix;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } entry_t;

  // mode 0 maps 0..255 linearly onto the 25-step code range; mode 1 keeps the top bits
  function automatic logic [4:0] quantize(input logic mode, input logic [7:0] x);
    logic [9:0] t;
    t = {2'b00, x} + {1'b0, x, 1'b0} + 10'd16;
    return mode ? x[7:3] : t[9:5];
  endfunction

  function automatic logic active_edge(input logic cur, input logic prev, input logic pol);
    return (cur == pol) && (prev != pol);
  endfunction

endpackage

// File: rtl/vadc_fifo.sv
// First-word-fall-through FIFO; the head entry is visible whenever empty_o is low.
module vadc_fifo
  import vadc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);

  // a read frees the slot, so a full FIFO still accepts a write in the same cycle
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem[rd_ptr_q];

endmodule

// File: rtl/vadc_capture.sv
// Video capture front end: samples RGB + syncs, tracks beam position, windows
// the active area, quantizes to 5-bit codes and streams pixels out of a small FIFO.
module vadc_capture
  import vadc_pkg::*;
#(
  parameter logic       HS_POL     = 1'b0,
  parameter logic       VS_POL     = 1'b0,
  parameter logic [9:0] H_START    = 10'd128,
  parameter logic [9:0] H_ACTIVE   = 10'd360,
  parameter logic [9:0] V_START    = 10'd32,
  parameter logic [9:0] V_ACTIVE   = 10'd288,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         red_i,
  input  logic [7:0]         grn_i,
  input  logic [7:0]         blu_i,
  input  logic               hsync_i,
  input  logic               vsync_i,
  input  logic               vadc_mode,
  input  logic               enable,
  input  logic               ovf_clr,
  output logic [PIX_W-1:0]   pix_data,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               armed,
  output logic               ovf,
  output logic [10:0]        line_len
);

  localparam logic [10:0] H_END = {1'b0, H_START} + {1'b0, H_ACTIVE};
  localparam logic [10:0] V_END = {1'b0, V_START} + {1'b0, V_ACTIVE};

  logic [7:0]         red_q, grn_q, blu_q;
  logic               hs_q, vs_q, hs_prev_q, vs_prev_q;
  logic [COORD_W-1:0] hcnt_q, hcnt_d;
  logic [COORD_W-1:0] vcnt_q, vcnt_d;
  logic [10:0]        line_len_q, line_len_d;
  logic               armed_q, armed_d;
  logic               ovf_q, ovf_d;
  logic               wr_en_q, wr_en_d;
  entry_t             wr_entry_q, wr_entry_d;

  logic               hs_edge, vs_edge;
  logic               in_h, in_v, capture;
  logic               fifo_full, fifo_empty, pop, drop;
  entry_t             head;

  assign hs_edge = active_edge(hs_q, hs_prev_q, HS_POL);
  assign vs_edge = active_edge(vs_q, vs_prev_q, VS_POL);

  assign in_h    = ({1'b0, hcnt_q} >= {1'b0, H_START}) && ({1'b0, hcnt_q} < H_END);
  assign in_v    = ({1'b0, vcnt_q} >= {1'b0, V_START}) && ({1'b0, vcnt_q} < V_END);
  assign capture = armed_q && in_h && in_v;

  assign pix_valid = !fifo_empty;
  assign pop       = pix_valid && pix_ready;
  assign drop      = wr_en_q && fifo_full && !pop;

  always_comb begin
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    line_len_d = line_len_q;
    armed_d    = armed_q;
    ovf_d      = ovf_q;

    if (hs_edge) begin
      hcnt_d     = '0;
      line_len_d = {1'b0, hcnt_q} + 11'd1;
      if (vcnt_q != '1) vcnt_d = vcnt_q + COORD_W'(1);
    end else if (hcnt_q != '1) begin
      hcnt_d = hcnt_q + COORD_W'(1);
    end
    if (vs_edge) vcnt_d = '0;

    // arming only happens at frame start; dropping enable takes effect at once
    if (!enable)      armed_d = 1'b0;
    else if (vs_edge) armed_d = 1'b1;

    // a new drop wins over a simultaneous clear
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_comb begin
    wr_en_d          = capture;
    wr_entry_d.pix.r = quantize(vadc_mode, red_q);
    wr_entry_d.pix.g = quantize(vadc_mode, grn_q);
    wr_entry_d.pix.b = quantize(vadc_mode, blu_q);
    wr_entry_d.x     = hcnt_q - H_START;
    wr_entry_d.y     = vcnt_q - V_START;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_q      <= '0;
      grn_q      <= '0;
      blu_q      <= '0;
      hs_q       <= !HS_POL;
      vs_q       <= !VS_POL;
      hs_prev_q  <= !HS_POL;
      vs_prev_q  <= !VS_POL;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      line_len_q <= '0;
      armed_q    <= 1'b0;
      ovf_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_entry_q <= '0;
    end else begin
      red_q      <= red_i;
      grn_q      <= grn_i;
      blu_q      <= blu_i;
      hs_q       <= hsync_i;
      vs_q       <= vsync_i;
      hs_prev_q  <= hs_q;
      vs_prev_q  <= vs_q;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      line_len_q <= line_len_d;
      armed_q    <= armed_d;
      ovf_q      <= ovf_d;
      wr_en_q    <= wr_en_d;
      wr_entry_q <= wr_entry_d;
    end
  end

  vadc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en_q),
    .wr_data_i (wr_entry_q),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // head memory is unreset, so keep the stream outputs at zero while empty
  assign pix_data = pix_valid ? head.pix : '0;
  assign pix_x    = pix_valid ? head.x   : '0;
  assign pix_y    = pix_valid ? head.y   : '0;
  assign armed    = armed_q;
  assign ovf      = ovf_q;
  assign line_len = line_len_q;

endmodule

// File: tb/tb_vadc_capture.sv
// Directed/random bench for vadc_capture using a small window and a frame-level pixel model.
module tb_vadc_capture;

  localparam int H_START = 2;
  localparam int H_ACTIVE = 3;
  localparam int V_START = 1;
  localparam int V_ACTIVE = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  red_i = '0, grn_i = '0, blu_i = '0;
  logic        hsync_i = 1'b0, vsync_i = 1'b0;
  logic        vadc_mode = 1'b0, enable = 1'b0, ovf_clr = 1'b0, pix_ready = 1'b0;
  logic [14:0] pix_data;
  logic [9:0]  pix_x, pix_y;
  logic        pix_valid, armed, ovf;
  logic [10:0] line_len;

  vadc_capture #(
    .HS_POL(1'b1), .VS_POL(1'b1),
    .H_START(10'(H_START)), .H_ACTIVE(10'(H_ACTIVE)),
    .V_START(10'(V_START)), .V_ACTIVE(10'(V_ACTIVE)),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .red_i(red_i), .grn_i(grn_i), .blu_i(blu_i),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .vadc_mode(vadc_mode), .enable(enable),
    .ovf_clr(ovf_clr), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .armed(armed), .ovf(ovf),
    .line_len(line_len)
  );

  always #5 clk = ~clk;

  logic [34:0] exp_q [$];
  int checks = 0, errors = 0;
  bit frame_armed = 0, exp_ovf = 0;
  int rdy_mode = 0, cyc_n = 0, last_len = 0, edges = 0;
  int sweep_mode = 0, sweep_k = 0;
  logic [7:0] sweep_x [6] = '{8'd0, 8'd5, 8'd10, 8'd16, 8'd128, 8'd255};
  logic [4:0] sweep_q [6] = '{5'd0, 5'd0, 5'd1, 5'd2, 5'd12, 5'd24};

  function automatic logic [4:0] qref(input logic m, input int x);
    return m ? 5'(x / 8) : 5'((3 * x + 16) / 32);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // one clock: apply inputs, score any pop that happens at the coming edge
  task automatic cyc(input logic hs, input logic vs, input logic [7:0] r, input logic [7:0] g,
                     input logic [7:0] b);
    logic [34:0] e;
    hsync_i = hs; vsync_i = vs; red_i = r; grn_i = g; blu_i = b;
    pix_ready = (rdy_mode == 1) || (rdy_mode == 2 && (cyc_n % 2) == 1);
    if (pix_valid && pix_ready) begin
      if (exp_q.size() == 0) begin
        chk("pix_extra_valid", 64'(pix_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pix_head", 64'({pix_data, pix_x, pix_y}), 64'(e));
        $display("pix x=%0d y=%0d data=%h", pix_x, pix_y, pix_data);
      end
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    last_len += n;
  endtask

  // one video line; sync active for its first two samples; column c carries hcnt = c-1
  task automatic line(input int len, input bit vs_start, input int vidx, input int drop_at,
                      input bit lat_chk);
    logic [7:0] r, g, b;
    logic [4:0] rq;
    int hc;
    for (int c = 0; c < len; c++) begin
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      if (c == drop_at) enable = 1'b0;
      if (vs_start && c == 1) frame_armed = enable;
      if (!enable) frame_armed = 0;
      hc = c - 1;
      if (c >= 1 && frame_armed && hc >= H_START && hc < H_START + H_ACTIVE &&
          vidx >= V_START && vidx < V_START + V_ACTIVE) begin
        rq = qref(vadc_mode, int'(r));
        if (sweep_mode == 1 && sweep_k < 6) begin
          r = sweep_x[sweep_k]; rq = sweep_q[sweep_k];
        end else if (sweep_mode == 2 && sweep_k == 0) begin
          r = 8'hF8; rq = 5'd31;
        end
        sweep_k++;
        if (rdy_mode == 0 && exp_q.size() >= DEPTH) exp_ovf = 1;
        else exp_q.push_back({rq, qref(vadc_mode, int'(g)), qref(vadc_mode, int'(b)),
                              10'(hc - H_START), 10'(vidx - V_START)});
      end
      if (lat_chk && c == H_START + 3) chk("latency_not_yet", 64'(pix_valid), 64'd0);
      if (lat_chk && c == H_START + 4) chk("latency_valid", 64'(pix_valid), 64'd1);
      if (c == 1) edges++;
      if (c == len - 1 && edges >= 2) chk("line_len", 64'(line_len), 64'(last_len));
      cyc(c < 2, vs_start && c < 2, r, g, b);
    end
    last_len = len;
  endtask

  task automatic frame(input int drop_line, input int drop_at, input int raise_line,
                       input bit lat_chk);
    sweep_k = 0;
    for (int v = 0; v < 4; v++) begin
      if (v == raise_line) enable = 1'b1;
      line(12, v == 0, v, (v == drop_line) ? drop_at : -1, lat_chk && v == V_START);
    end
  endtask

  task automatic drained(input string tag);
    idle(8);
    chk(tag, 64'(exp_q.size()), 64'd0);
    chk({tag, "_valid"}, 64'(pix_valid), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(pix_valid), 64'd0);
    chk("rst_data", 64'({pix_data, pix_x, pix_y}), 64'd0);
    chk("rst_armed", 64'(armed), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_line_len", 64'(line_len), 64'd0);
    rst_n = 1'b1;
    idle(4);

    // quantizer sweep, mode 0, with window/latency checks
    rdy_mode = 1; vadc_mode = 1'b0; sweep_mode = 1; enable = 1'b1;
    frame(-1, -1, -1, 1'b1);
    chk("armed_on", 64'(armed), 64'd1);
    drained("drain_sweep0");

    // truncation mode
    vadc_mode = 1'b1; sweep_mode = 2;
    frame(-1, -1, -1, 1'b0);
    drained("drain_sweep1");

    // random pixels, alternating ready
    vadc_mode = 1'b0; sweep_mode = 0; rdy_mode = 2;
    frame(-1, -1, -1, 1'b0);
    drained("drain_alt_ready");
    rdy_mode = 1;

    // enable dropped mid-line, then raised mid-frame, then a normal frame
    frame(1, 4, -1, 1'b0);
    chk("armed_dropped", 64'(armed), 64'd0);
    frame(-1, -1, 1, 1'b0);
    chk("armed_midframe", 64'(armed), 64'd0);
    frame(-1, -1, -1, 1'b0);
    chk("armed_rearm", 64'(armed), 64'd1);
    drained("drain_arm");

    // backpressure: 6 pixels into a 4-deep FIFO
    rdy_mode = 0;
    frame(-1, -1, -1, 1'b0);
    idle(3);
    chk("bp_ovf", 64'(ovf), 64'(exp_ovf));
    chk("bp_valid", 64'(pix_valid), 64'd1);
    chk("bp_head_stable", 64'({pix_data, pix_x, pix_y}), 64'(exp_q[0]));
    rdy_mode = 1;
    drained("drain_bp");
    chk("bp_ovf_sticky", 64'(ovf), 64'd1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    exp_ovf = 0;
    idle(1);
    chk("ovf_cleared", 64'(ovf), 64'(exp_ovf));

    // 800-cycle line measurement
    line(800, 1'b0, 100, -1, 1'b0);
    line(12, 1'b0, 101, -1, 1'b0);
    chk("line_len_800", 64'(line_len), 64'd800);

    // async reset mid-line with three entries queued
    rdy_mode = 0;
    line(12, 1'b1, 0, -1, 1'b0);
    line(9, 1'b0, 1, -1, 1'b0);
    chk("pre_rst_queued", 64'(exp_q.size()), 64'd3);
    chk("pre_rst_valid", 64'(pix_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(pix_valid), 64'd0);
    chk("async_rst_ovf", 64'(ovf), 64'd0);
    chk("async_rst_armed", 64'(armed), 64'd0);
    exp_q.delete();
    frame_armed = 0; exp_ovf = 0; edges = 0; last_len = 0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    rdy_mode = 1;
    for (int v = 1; v < 4; v++) line(12, 1'b0, v, -1, 1'b0);
    chk("post_rst_unarmed", 64'(armed), 64'd0);
    chk("post_rst_no_pix", 64'(pix_valid), 64'd0);
    frame(-1, -1, -1, 1'b0);
    drained("drain_post_rst");
    chk("final_ovf", 64'(ovf), 64'(exp_ovf));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout got=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
